// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    // Access lengths in bytes
    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // Requester identifiers
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // Fixed priority with starvation override: LS normally wins a tie,
    // IF wins when it has been passed over too many times in a row.
    // Only meaningful when at least one request is present.
    function automatic logic arb_winner(input logic if_req,
                                        input logic ls_req,
                                        input logic at_limit);
        logic win;
        if (if_req && (!ls_req || at_limit)) begin
            win = REQ_IF;
        end else begin
            win = REQ_LS;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of LS grants taken while IF was waiting.
module mem_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [3:0] LIMIT_C = 4'(LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear has priority, increment saturates at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store,
// one transaction at a time, with starvation guard and timeout abort.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_len,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_len_q, mem_len_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ready_q, if_ready_d;
    logic        ls_ready_q, ls_ready_d;
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic [7:0]  timer_q, timer_d;

    logic starve_clr_s;
    logic starve_inc_s;
    logic at_limit_s;

    mem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (starve_clr_s),
        .inc_i     (starve_inc_s),
        .at_limit_o(at_limit_s)
    );

    // Next-state, transaction latching, timeout and response generation
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_len_d    = mem_len_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        timer_d      = timer_q;
        if_ready_d   = 1'b0;
        ls_ready_d   = 1'b0;
        err_d        = 1'b0;
        starve_clr_s = 1'b0;
        starve_inc_s = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = 8'd0;
                if (if_req || ls_req) begin
                    if (arb_winner(if_req, ls_req, at_limit_s) == REQ_IF) begin
                        state_d      = BUSY_IF;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_len_d    = LEN_W;
                        mem_addr_d   = if_addr;
                        mem_wdata_d  = 32'h0;
                        starve_clr_s = 1'b1;
                    end else begin
                        state_d      = BUSY_LS;
                        mem_req_d    = 1'b1;
                        mem_we_d     = ls_we;
                        mem_len_d    = ls_len;
                        mem_addr_d   = ls_addr;
                        mem_wdata_d  = ls_wdata;
                        starve_inc_s = if_req;
                        starve_clr_s = ~if_req;
                    end
                end else begin
                    // Nobody waiting: IF is not being starved
                    starve_clr_s = 1'b1;
                end
            end

            BUSY_IF, BUSY_LS: begin
                if (mem_ready) begin
                    // Completion wins over a timeout landing in the same cycle
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        ls_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            ls_rdata_d = mem_rdata;
                        end else begin
                            ls_rdata_d = ls_rdata_q;
                        end
                    end
                end else if (timer_q == TIMER_LAST) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    err_d     = 1'b1;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = 32'h0;
                        if_ready_d = 1'b1;
                    end else begin
                        ls_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            ls_rdata_d = 32'h0;
                        end else begin
                            ls_rdata_d = ls_rdata_q;
                        end
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
                timer_d = 8'd0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_len_q   <= 3'd0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_ready_q  <= 1'b0;
            ls_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= 32'h0;
            ls_rdata_q  <= 32'h0;
            timer_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_len_q   <= mem_len_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            ls_ready_q  <= ls_ready_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            timer_q     <= timer_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_len   = mem_len_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign ls_ready  = ls_ready_q;
    assign err       = err_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule
